// File: rtl/neuron_fabric_pkg.sv
// neuron_fabric_pkg
// Shared definitions for the neuron core Wishbone fabric.
//   - fabric_state_t : host-side transaction FSM states
//   - CSR_*          : word offsets (adr[3:2]) inside the local CSR window
//   - ERR_DATA       : read data returned on decode errors and timeouts
//   - ID_MAGIC       : low half of the read-only ID register
package neuron_fabric_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_RESP = 2'd2
  } fabric_state_t;

  localparam logic [1:0] CSR_STATUS    = 2'd0;
  localparam logic [1:0] CSR_TXN_COUNT = 2'd1;
  localparam logic [1:0] CSR_ID        = 2'd2;
  localparam logic [1:0] CSR_RSVD      = 2'd3;

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
  localparam logic [15:0] ID_MAGIC = 16'hEB01;

endpackage

// File: rtl/neuron_fabric_csr.sv
// neuron_fabric_csr
// Local register window of the fabric: sticky fault status, transaction
// counter and a read-only ID word.
// Ports:
//   clk, rst   : clock and asynchronous active-high reset
//   wr_en      : CSR write strobe for this cycle
//   offset     : word offset of the access (adr[3:2])
//   wr_bits    : host write data bits [1:0] (W1C clear mask for STATUS)
//   set_tmo    : core ack timeout occurred this cycle
//   set_dec    : address decode error occurred this cycle
//   err_idx    : window index to record in LAST_IDX on a fault
//   txn_inc    : a forwarded core transaction completed this cycle
//   rd_data    : combinational read mux for the addressed register
//   irq        : high while any sticky fault bit is set
module neuron_fabric_csr
  import neuron_fabric_pkg::*;
#(
  parameter int N_CORES = 4,
  parameter int CORE_AW = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [1:0]  offset,
  input  logic [1:0]  wr_bits,
  input  logic        set_tmo,
  input  logic        set_dec,
  input  logic [3:0]  err_idx,
  input  logic        txn_inc,
  output logic [31:0] rd_data,
  output logic        irq
);

  localparam logic [31:0] ID_VALUE = {8'(N_CORES), 8'(CORE_AW), ID_MAGIC};

  logic        tmo_err;
  logic        dec_err;
  logic [3:0]  last_idx;
  logic [31:0] txn_count;
  logic        clr_tmo;
  logic        clr_dec;
  logic        clr_txn;

  assign clr_tmo = wr_en && (offset == CSR_STATUS) && wr_bits[0];
  assign clr_dec = wr_en && (offset == CSR_STATUS) && wr_bits[1];
  assign clr_txn = wr_en && (offset == CSR_TXN_COUNT);

  // Sticky fault bits. A fault arriving in the same cycle as a W1C clear
  // must not be lost, so the set is tested first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_err  <= 1'b0;
      dec_err  <= 1'b0;
      last_idx <= 4'd0;
    end else begin
      if (set_tmo) begin
        tmo_err <= 1'b1;
      end else if (clr_tmo) begin
        tmo_err <= 1'b0;
      end
      if (set_dec) begin
        dec_err <= 1'b1;
      end else if (clr_dec) begin
        dec_err <= 1'b0;
      end
      if (set_tmo || set_dec) begin
        last_idx <= err_idx;
      end
    end
  end

  // Completed-transaction counter; any write clears it, otherwise it
  // wraps naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txn_count <= 32'd0;
    end else if (clr_txn) begin
      txn_count <= 32'd0;
    end else if (txn_inc) begin
      txn_count <= txn_count + 32'd1;
    end
  end

  // Read mux; the reserved slot reads as zero.
  always_comb begin
    rd_data = 32'd0;
    case (offset)
      CSR_STATUS:    rd_data = {20'd0, last_idx, 6'd0, dec_err, tmo_err};
      CSR_TXN_COUNT: rd_data = txn_count;
      CSR_ID:        rd_data = ID_VALUE;
      default:       rd_data = 32'd0;
    endcase
  end

  assign irq = tmo_err | dec_err;

endmodule

// File: rtl/neuron_fabric_wb.sv
// neuron_fabric_wb
// Wishbone fabric placing N_CORES neuron cores plus one CSR window behind
// a single host slave port. One transaction is in flight at a time.
// Ports:
//   clk, rst              : Wishbone clock, asynchronous active-high reset
//   wbs_*_i               : host classic Wishbone request
//   wbs_ack_o, wbs_dat_o  : registered host response
//   core_cyc_o/stb_o      : one-hot per-core strobes
//   core_we/sel/adr/dat_o : request fields broadcast to every core
//   core_ack_i, core_dat_i: per-core responses (core i at [32i+31:32i])
//   irq_o                 : level interrupt, high while a fault is sticky
module neuron_fabric_wb
  import neuron_fabric_pkg::*;
#(
  parameter int          N_CORES     = 4,
  parameter int          CORE_AW     = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          TIMEOUT_CYC = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [31:0]             wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  output logic [N_CORES-1:0]      core_cyc_o,
  output logic [N_CORES-1:0]      core_stb_o,
  output logic                    core_we_o,
  output logic [3:0]              core_sel_o,
  output logic [CORE_AW-1:0]      core_adr_o,
  output logic [31:0]             core_dat_o,
  input  logic [N_CORES-1:0]      core_ack_i,
  input  logic [32*N_CORES-1:0]   core_dat_i,
  output logic                    irq_o
);

  localparam int             IDXW     = $clog2(N_CORES + 1);
  localparam int             HI_LSB   = CORE_AW + IDXW;
  localparam logic [IDXW-1:0] CSR_IDX = IDXW'(N_CORES);
  localparam logic [15:0]    TMO_LAST = 16'(TIMEOUT_CYC - 1);

  fabric_state_t    state;
  fabric_state_t    next_state;

  logic [IDXW-1:0]    req_idx;
  logic               addr_hit;
  logic               is_core;
  logic               is_csr;

  logic [IDXW-1:0]    cur_idx;
  logic               lat_we;
  logic [3:0]         lat_sel;
  logic [CORE_AW-1:0] lat_adr;
  logic [31:0]        lat_dat;
  logic [31:0]        dat_q;
  logic [15:0]        tmo_cnt;

  logic               sel_ack;
  logic [31:0]        sel_dat;

  logic               latch_req;
  logic               load_dat;
  logic [31:0]        dat_next;
  logic               csr_wr;
  logic               set_tmo;
  logic               set_dec;
  logic               txn_inc;
  logic [IDXW-1:0]    err_src;
  logic [31:0]        csr_rdata;
  logic               csr_irq;

  assign req_idx  = wbs_adr_i[CORE_AW +: IDXW];
  assign addr_hit = (wbs_adr_i[31:HI_LSB] == BASE_ADDR[31:HI_LSB]);
  assign is_core  = addr_hit && (req_idx < CSR_IDX);
  assign is_csr   = addr_hit && (req_idx == CSR_IDX);

  // Select the ack and read data of the core currently being forwarded to;
  // acks from every other core are simply not looked at.
  always_comb begin
    sel_ack = 1'b0;
    sel_dat = 32'd0;
    for (int i = 0; i < N_CORES; i++) begin
      if (cur_idx == IDXW'(i)) begin
        sel_ack = core_ack_i[i];
        sel_dat = core_dat_i[32*i +: 32];
      end
    end
  end

  // Strobes are decoded straight from the state register so a reset drops
  // them immediately, without waiting for a clock edge.
  always_comb begin
    core_cyc_o = '0;
    for (int i = 0; i < N_CORES; i++) begin
      core_cyc_o[i] = (state == ST_FWD) && (cur_idx == IDXW'(i));
    end
  end

  assign core_stb_o = core_cyc_o;
  assign core_we_o  = lat_we;
  assign core_sel_o = lat_sel;
  assign core_adr_o = lat_adr;
  assign core_dat_o = lat_dat;
  assign wbs_ack_o  = (state == ST_RESP);
  assign wbs_dat_o  = dat_q;
  assign irq_o      = csr_irq;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and per-cycle control. In FWD a host abort outranks a core
  // ack, which in turn outranks the timeout firing in the same cycle.
  always_comb begin
    next_state = state;
    latch_req  = 1'b0;
    load_dat   = 1'b0;
    dat_next   = 32'd0;
    csr_wr     = 1'b0;
    set_tmo    = 1'b0;
    set_dec    = 1'b0;
    txn_inc    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          if (is_core) begin
            latch_req  = 1'b1;
            next_state = ST_FWD;
          end else if (is_csr) begin
            csr_wr     = wbs_we_i;
            load_dat   = 1'b1;
            dat_next   = wbs_we_i ? 32'd0 : csr_rdata;
            next_state = ST_RESP;
          end else begin
            set_dec    = 1'b1;
            load_dat   = 1'b1;
            dat_next   = ERR_DATA;
            next_state = ST_RESP;
          end
        end
      end
      ST_FWD: begin
        if (!wbs_cyc_i) begin
          next_state = ST_IDLE;
        end else if (sel_ack) begin
          txn_inc    = 1'b1;
          load_dat   = 1'b1;
          dat_next   = lat_we ? 32'd0 : sel_dat;
          next_state = ST_RESP;
        end else if (tmo_cnt == TMO_LAST) begin
          set_tmo    = 1'b1;
          load_dat   = 1'b1;
          dat_next   = ERR_DATA;
          next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Request latch, response register and timeout counter. The counter only
  // runs while staying in FWD, so it is zero on every entry to FWD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_idx <= '0;
      lat_we  <= 1'b0;
      lat_sel <= 4'd0;
      lat_adr <= '0;
      lat_dat <= 32'd0;
      dat_q   <= 32'd0;
      tmo_cnt <= 16'd0;
    end else begin
      if (latch_req) begin
        cur_idx <= req_idx;
        lat_we  <= wbs_we_i;
        lat_sel <= wbs_sel_i;
        lat_adr <= wbs_adr_i[CORE_AW-1:0];
        lat_dat <= wbs_dat_i;
      end
      if (load_dat) begin
        dat_q <= dat_next;
      end
      if ((state == ST_FWD) && (next_state == ST_FWD)) begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end else begin
        tmo_cnt <= 16'd0;
      end
    end
  end

  assign err_src = (state == ST_FWD) ? cur_idx : req_idx;

  neuron_fabric_csr #(
    .N_CORES (N_CORES),
    .CORE_AW (CORE_AW)
  ) u_csr (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (csr_wr),
    .offset  (wbs_adr_i[3:2]),
    .wr_bits (wbs_dat_i[1:0]),
    .set_tmo (set_tmo),
    .set_dec (set_dec),
    .err_idx (4'(err_src)),
    .txn_inc (txn_inc),
    .rd_data (csr_rdata),
    .irq     (csr_irq)
  );

endmodule

// File: tb/tb_neuron_fabric_wb.sv
// tb_neuron_fabric_wb
// Self-checking bench for neuron_fabric_wb (N_CORES=4, CORE_AW=12,
// TIMEOUT_CYC=8). Inputs change and outputs are sampled on the falling edge.
module tb_neuron_fabric_wb;

  localparam int NC = 4;

  logic            clk;
  logic            rst;
  logic            wbs_cyc_i;
  logic            wbs_stb_i;
  logic            wbs_we_i;
  logic [3:0]      wbs_sel_i;
  logic [31:0]     wbs_adr_i;
  logic [31:0]     wbs_dat_i;
  logic            wbs_ack_o;
  logic [31:0]     wbs_dat_o;
  logic [NC-1:0]   core_cyc_o;
  logic [NC-1:0]   core_stb_o;
  logic            core_we_o;
  logic [3:0]      core_sel_o;
  logic [11:0]     core_adr_o;
  logic [31:0]     core_dat_o;
  logic [NC-1:0]   core_ack_i;
  logic [32*NC-1:0] core_dat_i;
  logic            irq_o;

  neuron_fabric_wb #(
    .N_CORES     (NC),
    .CORE_AW     (12),
    .BASE_ADDR   (32'h3000_0000),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wbs_cyc_i  (wbs_cyc_i),
    .wbs_stb_i  (wbs_stb_i),
    .wbs_we_i   (wbs_we_i),
    .wbs_sel_i  (wbs_sel_i),
    .wbs_adr_i  (wbs_adr_i),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_ack_o  (wbs_ack_o),
    .wbs_dat_o  (wbs_dat_o),
    .core_cyc_o (core_cyc_o),
    .core_stb_o (core_stb_o),
    .core_we_o  (core_we_o),
    .core_sel_o (core_sel_o),
    .core_adr_o (core_adr_o),
    .core_dat_o (core_dat_o),
    .core_ack_i (core_ack_i),
    .core_dat_i (core_dat_i),
    .irq_o      (irq_o)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] wdat;
    int          ack_delay;
    logic [31:0] rdat;
    logic [31:0] exp_dat;
    int          exp_lat;
    int          exp_stb;
    logic [3:0]  exp_mask;
    logic        exp_irq;
  } vec_t;

  vec_t        vecs[$];
  int          checks;
  int          errors;

  logic [31:0] got_dat;
  int          got_lat;
  int          got_stb;
  logic [3:0]  got_mask;
  logic        got_irq;
  logic [11:0] seen_adr;
  logic        seen_we;
  logic [3:0]  seen_sel;
  logic [31:0] seen_wdat;

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%08h expected=0x%08h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic we, input logic [3:0] sel,
                              input logic [31:0] adr, input logic [31:0] wdat, input int ack_delay,
                              input logic [31:0] rdat, input logic [31:0] exp_dat, input int exp_lat,
                              input int exp_stb, input logic [3:0] exp_mask, input logic exp_irq);
    vec_t v;
    v.name = name; v.we = we; v.sel = sel; v.adr = adr; v.wdat = wdat;
    v.ack_delay = ack_delay; v.rdat = rdat; v.exp_dat = exp_dat; v.exp_lat = exp_lat;
    v.exp_stb = exp_stb; v.exp_mask = exp_mask; v.exp_irq = exp_irq;
    return v;
  endfunction

  // One host transaction with a behavioural core responder: the strobed core
  // acks on its (ack_delay+1)-th strobe cycle (never if ack_delay<0), and a
  // neighbouring core throws a stray ack on the first strobe cycle.
  task automatic applyStimulus(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                               input logic [31:0] wdat, input int ack_delay, input logic [31:0] rdat);
    logic got_ack;
    int   tgt;
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_sel_i = sel;  wbs_adr_i = adr;  wbs_dat_i = wdat;
    got_ack = 1'b0; got_lat = 0; got_stb = 0; got_mask = '0; got_dat = '0; got_irq = 1'b0;
    tgt = 0;
    for (int c = 1; c <= 50 && !got_ack; c++) begin
      @(negedge clk);
      core_ack_i = '0;
      if (wbs_ack_o) begin
        got_ack = 1'b1;
        got_lat = c;
        got_dat = wbs_dat_o;
        got_irq = irq_o;
      end else if (core_stb_o != '0) begin
        got_stb++;
        got_mask |= core_stb_o;
        seen_adr = core_adr_o; seen_we = core_we_o;
        seen_sel = core_sel_o; seen_wdat = core_dat_o;
        for (int i = 0; i < NC; i++) if (core_stb_o[i]) tgt = i;
        if (ack_delay >= 0 && got_stb == ack_delay + 1) begin
          core_ack_i[tgt] = 1'b1;
          core_dat_i[32*tgt +: 32] = rdat;
        end else if (got_stb == 1 && ack_delay != 0) begin
          core_ack_i[(tgt + 1) % NC] = 1'b1;
        end
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; core_ack_i = '0;
    if (!got_ack) begin
      checks++;
      errors++;
      $display("[TB] FAIL ack_wait no wbs_ack_o within 50 cycles adr=0x%08h", adr);
    end
  endtask

  task automatic runVec(input vec_t v);
    applyStimulus(v.we, v.sel, v.adr, v.wdat, v.ack_delay, v.rdat);
    checkOutput({v.name, "_dat"}, got_dat, v.exp_dat);
    checkOutput({v.name, "_lat"}, 32'(got_lat), 32'(v.exp_lat));
    checkOutput({v.name, "_irq"}, {31'd0, got_irq}, {31'd0, v.exp_irq});
    checkOutput({v.name, "_mask"}, {28'd0, got_mask}, {28'd0, v.exp_mask});
    if (v.exp_mask != 4'd0) begin
      checkOutput({v.name, "_stbcyc"}, 32'(got_stb), 32'(v.exp_stb));
      checkOutput({v.name, "_cadr"}, {20'd0, seen_adr}, {20'd0, v.adr[11:0]});
      checkOutput({v.name, "_cwesel"}, {27'd0, seen_we, seen_sel}, {27'd0, v.we, v.sel});
      checkOutput({v.name, "_cdat"}, seen_wdat, v.wdat);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = 4'd0; wbs_adr_i = 32'd0; wbs_dat_i = 32'd0;
    core_ack_i = '0;
    for (int i = 0; i < NC; i++) core_dat_i[32*i +: 32] = 32'h5EED_0000 | 32'(i);

    //        name            we sel    adr            wdat           dly rdat           exp_dat        lat stb mask    irq
    vecs.push_back(mk("rd_core2",     0, 4'hF, 32'h3000_2010, 32'h0BAD_0002,  3, 32'h1234_5678, 32'h1234_5678, 5, 4, 4'b0100, 0));
    vecs.push_back(mk("rd_txn1",      0, 4'hF, 32'h3000_4004, 32'h0,         -1, 32'h0,         32'h0000_0001, 1, 0, 4'b0000, 0));
    vecs.push_back(mk("wr_core1",     1, 4'h3, 32'h3000_1ABC, 32'hA5A5_0001,  0, 32'hFFFF_FFFF, 32'h0,         2, 1, 4'b0010, 0));
    vecs.push_back(mk("rd_core3",     0, 4'hF, 32'h3000_3FFC, 32'h0,          1, 32'hCAFE_F00D, 32'hCAFE_F00D, 3, 2, 4'b1000, 0));
    vecs.push_back(mk("rd_txn3",      0, 4'hF, 32'h3000_4004, 32'h0,         -1, 32'h0,         32'h0000_0003, 1, 0, 4'b0000, 0));
    vecs.push_back(mk("rd_id",        0, 4'hF, 32'h3000_4008, 32'h0,         -1, 32'h0,         32'h040C_EB01, 1, 0, 4'b0000, 0));
    vecs.push_back(mk("rd_rsvd",      0, 4'hF, 32'h3000_400C, 32'h0,         -1, 32'h0,         32'h0,         1, 0, 4'b0000, 0));
    vecs.push_back(mk("wr_rsvd",      1, 4'hF, 32'h3000_400C, 32'hFFFF_FFFF, -1, 32'h0,         32'h0,         1, 0, 4'b0000, 0));
    vecs.push_back(mk("wr_txn_clr",   1, 4'h0, 32'h3000_4004, 32'h0,         -1, 32'h0,         32'h0,         1, 0, 4'b0000, 0));
    vecs.push_back(mk("rd_txn0",      0, 4'hF, 32'h3000_4004, 32'h0,         -1, 32'h0,         32'h0,         1, 0, 4'b0000, 0));
    vecs.push_back(mk("rd_stat0",     0, 4'hF, 32'h3000_4000, 32'h0,         -1, 32'h0,         32'h0,         1, 0, 4'b0000, 0));
    vecs.push_back(mk("miss",         0, 4'hF, 32'h2000_5000, 32'h0,         -1, 32'h0,         32'hDEAD_BEEF, 1, 0, 4'b0000, 1));
    vecs.push_back(mk("rd_stat502",   0, 4'hF, 32'h3000_4000, 32'h0,         -1, 32'h0,         32'h0000_0502, 1, 0, 4'b0000, 1));
    vecs.push_back(mk("dec_idx6",     0, 4'hF, 32'h3000_6000, 32'h0,         -1, 32'h0,         32'hDEAD_BEEF, 1, 0, 4'b0000, 1));
    vecs.push_back(mk("rd_stat602",   0, 4'hF, 32'h3000_4000, 32'h0,         -1, 32'h0,         32'h0000_0602, 1, 0, 4'b0000, 1));
    vecs.push_back(mk("w1c_tmo_only", 1, 4'hF, 32'h3000_4000, 32'h0000_0001, -1, 32'h0,         32'h0,         1, 0, 4'b0000, 1));
    vecs.push_back(mk("rd_stat_keep", 0, 4'hF, 32'h3000_4000, 32'h0,         -1, 32'h0,         32'h0000_0602, 1, 0, 4'b0000, 1));
    vecs.push_back(mk("w1c_dec",      1, 4'hF, 32'h3000_4000, 32'h0000_0002, -1, 32'h0,         32'h0,         1, 0, 4'b0000, 0));
    vecs.push_back(mk("rd_stat600",   0, 4'hF, 32'h3000_4000, 32'h0,         -1, 32'h0,         32'h0000_0600, 1, 0, 4'b0000, 0));
    vecs.push_back(mk("tmo_core0",    1, 4'hF, 32'h3000_0020, 32'h1357_9BDF, -1, 32'h0,         32'hDEAD_BEEF, 9, 8, 4'b0001, 1));
    vecs.push_back(mk("rd_stat001",   0, 4'hF, 32'h3000_4000, 32'h0,         -1, 32'h0,         32'h0000_0001, 1, 0, 4'b0000, 1));
    vecs.push_back(mk("rd_txn_tmo",   0, 4'hF, 32'h3000_4004, 32'h0,         -1, 32'h0,         32'h0,         1, 0, 4'b0000, 1));
    vecs.push_back(mk("w1c_tmo",      1, 4'hF, 32'h3000_4000, 32'h0000_0001, -1, 32'h0,         32'h0,         1, 0, 4'b0000, 0));
    vecs.push_back(mk("rd_stat_clr",  0, 4'hF, 32'h3000_4000, 32'h0,         -1, 32'h0,         32'h0,         1, 0, 4'b0000, 0));

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
    checkOutput("rst_dat", wbs_dat_o, 32'd0);
    checkOutput("rst_strobes", {24'd0, core_cyc_o, core_stb_o}, 32'd0);
    checkOutput("rst_irq", {31'd0, irq_o}, 32'd0);
    checkOutput("rst_core_ctl", {15'd0, core_we_o, core_sel_o, core_adr_o}, 32'd0);
    checkOutput("rst_core_dat", core_dat_o, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) runVec(vecs[i]);

    // Host abandons a forwarded read; the core's late ack must be ignored.
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_sel_i = 4'hF; wbs_adr_i = 32'h3000_1004; wbs_dat_i = 32'h0;
    @(negedge clk);
    checkOutput("abort_stb_on", {28'd0, core_stb_o}, 32'h0000_0002);
    @(negedge clk);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(negedge clk);
    checkOutput("abort_stb_off", {28'd0, core_stb_o}, 32'd0);
    checkOutput("abort_no_ack0", {31'd0, wbs_ack_o}, 32'd0);
    core_ack_i[1] = 1'b1;
    @(negedge clk);
    checkOutput("abort_no_ack1", {31'd0, wbs_ack_o}, 32'd0);
    core_ack_i = '0;
    @(negedge clk);
    checkOutput("abort_no_ack2", {31'd0, wbs_ack_o}, 32'd0);
    runVec(mk("abort_txn0",  0, 4'hF, 32'h3000_4004, 32'h0, -1, 32'h0,         32'h0,         1, 0, 4'b0000, 0));
    runVec(mk("after_abort", 0, 4'hF, 32'h3000_1008, 32'h0,  0, 32'h7777_1111, 32'h7777_1111, 2, 1, 4'b0010, 0));
    runVec(mk("abort_txn1",  0, 4'hF, 32'h3000_4004, 32'h0, -1, 32'h0,         32'h0000_0001, 1, 0, 4'b0000, 0));

    // Reset while a core access is in flight.
    runVec(mk("pre_rst_dec", 0, 4'hF, 32'h3000_7000, 32'h0, -1, 32'h0, 32'hDEAD_BEEF, 1, 0, 4'b0000, 1));
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_sel_i = 4'hF; wbs_adr_i = 32'h3000_3000; wbs_dat_i = 32'h2468_ACE0;
    @(negedge clk);
    checkOutput("midrst_stb_on", {28'd0, core_stb_o}, 32'h0000_0008);
    rst = 1'b1;
    #1;
    checkOutput("midrst_strobes", {24'd0, core_cyc_o, core_stb_o}, 32'd0);
    checkOutput("midrst_ack_irq", {30'd0, wbs_ack_o, irq_o}, 32'd0);
    checkOutput("midrst_dat", wbs_dat_o, 32'd0);
    checkOutput("midrst_core", {15'd0, core_we_o, core_sel_o, core_adr_o} | core_dat_o, 32'd0);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    runVec(mk("post_rst_stat", 0, 4'hF, 32'h3000_4000, 32'h0, -1, 32'h0, 32'h0, 1, 0, 4'b0000, 0));
    runVec(mk("post_rst_txn",  0, 4'hF, 32'h3000_4004, 32'h0, -1, 32'h0, 32'h0, 1, 0, 4'b0000, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
